cl_job_replayer: RTL and testbench
==================================

Name: cl_job_replayer

Overview:
- Transmit-side counterpart of the job logging path.
- The host fills a job-record BRAM through a 32-bit write port, then triggers a replay.
- The block reads each 128-bit record back as 4 words, assembles a job and drives it as AXI-stream master on job_bus toward the pairhmm workers.
- Used to re-inject captured job sequences for debug and regression.

Parameters:
- REC_WORDS, 4, 32-bit words per job record (fixed by the record layout).
- NUM_RECORDS, 512, record slots; record index width is 9 bits and wraps.
- READ_LATENCY, 1, BRAM read latency in cycles.

Ports:
- clock_i  in  1  single clock.
- reset_ni  in  1  asynchronous, active-low reset.
- job_bus  master  axi_stream_generic_if  tdata is job_t; tvalid/tready handshake.
- host_wr_en_i  in  1  host write strobe.
- host_addr_i  in  11  word address = {record_idx[8:0], word[1:0]}.
- host_data_i  in  32  host write data.
- start_i  in  1  pulse; starts a replay.
- stop_i  in  1  level or pulse; requests abort.
- first_idx_i  in  9  first record index, sampled on start.
- num_jobs_i  in  10  job count 0..512, sampled on start.
- busy_o  out  1  replay in progress.
- done_o  out  1  one-cycle pulse at end of replay or abort.
- jobs_sent_o  out  10  jobs accepted in the current or last replay.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - state IDLE; tvalid 0; busy_o 0; done_o 0; jobs_sent_o 0.
  - BRAM contents are not cleared.
- Record layout:
  - word0 = initial_condition
  - word1 = hap_addr
  - word2 = {read_len_min_1[15:0], hap_len_min_1[15:0]}
  - word3 = read_addr
  - Fields are truncated to job_t widths; upper bits are ignored.
- Host writes take effect in the cycle after host_wr_en_i, in any state, with no protection. A record written before its word is fetched is replayed with the new value.
- Read and write of the same address in the same cycle returns the old data.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start_i with num_jobs_i>0: latch idx=first_idx_i and remaining=num_jobs_i; clear jobs_sent_o; go to FETCH.
  - start_i with num_jobs_i=0: go directly to DONE.
- FETCH:
  - Issue word addresses 0..3 on consecutive cycles.
  - Capture each word READ_LATENCY cycles after its address.
  - Enter SEND the cycle after word3 is captured.
- SEND: tvalid=1 with stable tdata until tready.
- On accept (tvalid&&tready):
  - jobs_sent_o increments.
  - idx increments, wrapping 511 -> 0.
  - remaining decrements.
  - If remaining becomes 0, go to DONE; otherwise go to FETCH.
- Latency:
  - tvalid rises 6 cycles after start_i is sampled.
  - After an accept in cycle A, the next tvalid rises at A+6.
  - Throughput is one job per 6 cycles with tready held high.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in FETCH and SEND only.
- stop_i:
  - In FETCH: discard the partial record, go to DONE.
  - In SEND: hold tvalid until the current beat is accepted (no retraction), then DONE.
  - In IDLE: ignored.
  - stop_i and start_i together in IDLE: start wins.
- start_i while busy is ignored.
- Async reset mid-replay: tvalid drops immediately and the partial job is lost.

Decomposition:
- Shared pairhmm package holds:
  - job_t
  - JOB_REC_WORDS = 4
  - JOB_REC_IDX_W = 9
  - word-offset constants JOB_W_INIT, JOB_W_HAPADDR, JOB_W_LENS, JOB_W_READADDR
  - The logger uses the same constants, so both sides share one record layout.
- One sub-module, cl_job_record_ram:
  - inferred simple dual-port RAM, 2048x32
  - write port: host
  - read port: replayer
  - registered read, READ_LATENCY=1

Test Plan:
- Write 3 records at idx 0..2 (read_addr 0x100,0x200,0x300, etc.); start with first_idx=0, num=3, tready=1 -> 3 beats with exact field values in order; tvalid first high at start+6; gap of 6 cycles between beats; done_o pulses once; jobs_sent_o=3.
- Back-pressure: tready=0 for 10 cycles during beat 1 -> tdata stable and tvalid held; no beat lost or duplicated.
- Wrap: first_idx=510, num=4 -> records 510, 511, 0, 1 emitted in that order.
- num_jobs=0 -> no tvalid; done_o pulses 2 cycles after start; busy_o stays 0.
- stop_i during FETCH of job 2 -> job 2 never emitted; done_o pulses; jobs_sent_o=1. stop_i during SEND -> current beat completes, then done_o.
- reset_ni low while tvalid=1 -> tvalid, busy_o and jobs_sent_o go to 0 immediately; after release, a new start replays correctly from the preserved BRAM contents.

Source files
------------

// File: rtl/cl_job_replayer_pkg.sv
// Job record layout shared by the job logger and the job replayer,
// plus the replayer state type and a record-word to job helper.
package cl_job_replayer_pkg;

   localparam int JOB_REC_WORDS = 4;
   localparam int JOB_REC_IDX_W = 9;
   localparam int JOB_WOFF_W    = $clog2(JOB_REC_WORDS);
   localparam int JOB_ADDR_W    = JOB_REC_IDX_W + JOB_WOFF_W;
   localparam int JOB_CNT_W     = JOB_REC_IDX_W + 1;

   localparam logic [JOB_WOFF_W-1:0] JOB_W_INIT     = JOB_WOFF_W'(0);
   localparam logic [JOB_WOFF_W-1:0] JOB_W_HAPADDR  = JOB_WOFF_W'(1);
   localparam logic [JOB_WOFF_W-1:0] JOB_W_LENS     = JOB_WOFF_W'(2);
   localparam logic [JOB_WOFF_W-1:0] JOB_W_READADDR = JOB_WOFF_W'(3);

   typedef struct packed {
      logic [31:0] initial_condition;
      logic [31:0] hap_addr;
      logic [15:0] read_len_min_1;
      logic [15:0] hap_len_min_1;
      logic [31:0] read_addr;
   } job_t;

   localparam int JOB_W = $bits(job_t);

   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND, ST_DONE} rep_state_e;

   // Fields narrower than a word keep only their low bits.
   function automatic job_t job_set_word(input job_t job, input logic [JOB_WOFF_W-1:0] sel,
                                         input logic [31:0] word);
      job_t j;
      j = job;
      case (sel)
         JOB_W_INIT:     j.initial_condition = word[$bits(j.initial_condition)-1:0];
         JOB_W_HAPADDR:  j.hap_addr          = word[$bits(j.hap_addr)-1:0];
         JOB_W_LENS: begin
            j.hap_len_min_1  = word[15:0];
            j.read_len_min_1 = word[31:16];
         end
         JOB_W_READADDR: j.read_addr         = word[$bits(j.read_addr)-1:0];
         default: ;
      endcase
      return j;
   endfunction

endpackage

// File: rtl/cl_job_record_ram.sv
// Simple dual-port job-record RAM: host write port, replayer read port.
// Read-first on a same-address collision; no reset so it maps onto block RAM.
module cl_job_record_ram #(
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clock_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q     [2**ADDR_W];
   logic [DATA_W-1:0] rd_pipe_q [READ_LATENCY];

   always_ff @(posedge clock_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_pipe_q[0] <= mem_q[rd_addr_i];
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
   end

   assign rd_data_o = rd_pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/cl_job_replayer.sv
// Replays host-loaded job records from BRAM onto the job stream: each
// record is fetched as four words, assembled into a job and sent as one beat.
module cl_job_replayer
   import cl_job_replayer_pkg::*;
#(
   parameter int REC_WORDS    = JOB_REC_WORDS,
   parameter int NUM_RECORDS  = 512,
   parameter int READ_LATENCY = 1
) (
   input  logic                     clock_i,
   input  logic                     reset_ni,
   output logic                     job_bus_tvalid_o,
   input  logic                     job_bus_tready_i,
   output logic [JOB_W-1:0]         job_bus_tdata_o,
   input  logic                     host_wr_en_i,
   input  logic [JOB_ADDR_W-1:0]    host_addr_i,
   input  logic [31:0]              host_data_i,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic [JOB_REC_IDX_W-1:0] first_idx_i,
   input  logic [JOB_CNT_W-1:0]     num_jobs_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [JOB_CNT_W-1:0]     jobs_sent_o
);

   localparam int IDX_W     = $clog2(NUM_RECORDS);
   localparam int FCNT_LAST = REC_WORDS - 1 + READ_LATENCY;
   localparam int FCNT_W    = $clog2(FCNT_LAST + 1);

   rep_state_e            state_q, state_d;
   logic [1:0]            rst_sync_q;
   logic                  rst_n;
   logic [IDX_W-1:0]      idx_q;
   logic [JOB_CNT_W-1:0]  remain_q, sent_q;
   logic [FCNT_W-1:0]     fcnt_q;
   job_t                  job_q;
   logic                  stop_pend_q, done_q;
   logic [JOB_ADDR_W-1:0] rd_addr;
   logic [31:0]           rd_data;
   logic                  cap_en, accept, end_after;
   logic [JOB_WOFF_W-1:0] cap_sel;

   // Reset asserts asynchronously but releases on a clock edge.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) rst_sync_q <= '0;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   cl_job_record_ram #(
      .ADDR_W       (JOB_ADDR_W),
      .DATA_W       (32),
      .READ_LATENCY (READ_LATENCY)
   ) u_ram (
      .clock_i   (clock_i),
      .wr_en_i   (host_wr_en_i),
      .wr_addr_i (host_addr_i),
      .wr_data_i (host_data_i),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clock_i or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   assign end_after = (remain_q == JOB_CNT_W'(1)) || stop_i || stop_pend_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = (num_jobs_i == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH: begin
            if (stop_i)                              state_d = ST_DONE;
            else if (fcnt_q == FCNT_W'(FCNT_LAST))   state_d = ST_SEND;
         end
         ST_SEND:  if (accept) state_d = end_after ? ST_DONE : ST_FETCH;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Word k is addressed at fcnt=k and lands READ_LATENCY cycles later.
   always_comb begin
      busy_o           = (state_q == ST_FETCH) || (state_q == ST_SEND);
      job_bus_tvalid_o = (state_q == ST_SEND);
      accept           = (state_q == ST_SEND) && job_bus_tready_i;
      rd_addr          = {idx_q, fcnt_q[JOB_WOFF_W-1:0]};
      cap_en           = (state_q == ST_FETCH) && (fcnt_q >= FCNT_W'(READ_LATENCY));
      cap_sel          = JOB_WOFF_W'(fcnt_q - FCNT_W'(READ_LATENCY));
   end

   always_ff @(posedge clock_i or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         remain_q    <= '0;
         sent_q      <= '0;
         fcnt_q      <= '0;
         job_q       <= '0;
         stop_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= (state_q == ST_DONE);
         fcnt_q <= (state_q == ST_FETCH) ? fcnt_q + FCNT_W'(1) : '0;
         if (state_q == ST_IDLE && start_i && num_jobs_i != '0) begin
            idx_q       <= first_idx_i;
            remain_q    <= num_jobs_i;
            sent_q      <= '0;
            stop_pend_q <= 1'b0;
         end
         if (cap_en) job_q <= job_set_word(job_q, cap_sel, rd_data);
         if (state_q == ST_SEND && stop_i) stop_pend_q <= 1'b1;
         if (accept) begin
            sent_q   <= sent_q + JOB_CNT_W'(1);
            idx_q    <= idx_q + IDX_W'(1);
            remain_q <= remain_q - JOB_CNT_W'(1);
         end
      end
   end

   assign job_bus_tdata_o = job_q;
   assign done_o          = done_q;
   assign jobs_sent_o     = sent_q;

endmodule

// File: tb/tb_cl_job_replayer.sv
// Randomized self-checking bench for cl_job_replayer against a record-array
// reference model with cycle-accurate beat, latency and done expectations.
module tb_cl_job_replayer;

   logic         clock = 1'b0;
   logic         reset_ni = 1'b1;
   logic         job_tvalid, job_tready;
   logic [127:0] job_tdata;
   logic         host_wr_en;
   logic [10:0]  host_addr;
   logic [31:0]  host_data;
   logic         start, stop;
   logic [8:0]   first_idx;
   logic [9:0]   num_jobs;
   logic         busy, done;
   logic [9:0]   jobs_sent;

   always #5 clock = ~clock;

   cl_job_replayer dut (
      .clock_i          (clock),
      .reset_ni         (reset_ni),
      .job_bus_tvalid_o (job_tvalid),
      .job_bus_tready_i (job_tready),
      .job_bus_tdata_o  (job_tdata),
      .host_wr_en_i     (host_wr_en),
      .host_addr_i      (host_addr),
      .host_data_i      (host_data),
      .start_i          (start),
      .stop_i           (stop),
      .first_idx_i      (first_idx),
      .num_jobs_i       (num_jobs),
      .busy_o           (busy),
      .done_o           (done),
      .jobs_sent_o      (jobs_sent)
   );

   // reference model: record fields by index
   logic [31:0]  rec_ic [512];
   logic [31:0]  rec_ha [512];
   logic [31:0]  rec_ln [512];
   logic [31:0]  rec_ra [512];
   logic [127:0] exp_q [$];
   int           model_sent = 0;

   int           n_tests = 0, n_fail = 0;
   int           cyc = 0;
   logic         pv = 1'b0, pacc = 1'b0;
   logic [127:0] pdata = '0;
   int           n_acc = 0, last_acc = 0, exp_rise = 0, n_done = 0, done_cyc = 0;
   bit           busy_seen = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_job(input int r);
      return {rec_ic[r], rec_ha[r], rec_ln[r][31:16], rec_ln[r][15:0], rec_ra[r]};
   endfunction

   task automatic mon();
      if (job_tvalid) begin
         if (!pv)        chk("rise_cycle", 128'(cyc), 128'(exp_rise));
         else if (!pacc) chk("hold_tdata", job_tdata, pdata);
         chk("busy_in_send", 128'(busy), 128'(1));
         if (job_tready) begin
            chk("beat_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) chk("beat_data", job_tdata, exp_q.pop_front());
            n_acc++;
            last_acc = cyc;
            exp_rise = cyc + 6;
         end
      end else if (pv && !pacc) begin
         chk("no_retract", 128'(job_tvalid), 128'(1));
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
      pv    = job_tvalid;
      pacc  = job_tvalid && job_tready;
      pdata = job_tdata;
   endtask

   task automatic step();
      @(negedge clock);
      mon();
      @(posedge clock);
      cyc++;
      #1;
   endtask

   task automatic write_rec(input int r, input logic [31:0] ic, input logic [31:0] ha,
                            input logic [31:0] ln, input logic [31:0] ra);
      logic [31:0] w [4];
      w = '{ic, ha, ln, ra};
      for (int k = 0; k < 4; k++) begin
         host_wr_en = 1'b1;
         host_addr  = 11'(r * 4 + k);
         host_data  = w[k];
         step();
      end
      host_wr_en = 1'b0;
      rec_ic[r] = ic; rec_ha[r] = ha; rec_ln[r] = ln; rec_ra[r] = ra;
   endtask

   // stop pulses stop_dly cycles after the stop_acc-th accept (or start)
   task automatic run(input int first, input int num, input int nexp, input int stall_beat,
                      input bit rnd, input int stop_acc, input int stop_dly, input string tag);
      int budget, stop_cyc, acc0, stall_cnt;
      for (int i = 0; i < nexp; i++) exp_q.push_back(exp_job((first + i) % 512));
      n_done = 0; busy_seen = 1'b0; stall_cnt = 0; stop_cyc = -1;
      first_idx = 9'(first);
      num_jobs  = 10'(num);
      start     = 1'b1;
      last_acc  = cyc;
      exp_rise  = cyc + 6;
      acc0      = n_acc;
      step();
      start  = 1'b0;
      budget = 400;
      while (n_done == 0 && budget > 0) begin
         budget--;
         stop = (stop_acc >= 0 && n_acc - acc0 == stop_acc && cyc == last_acc + stop_dly);
         if (stop) stop_cyc = cyc;
         job_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (n_acc - acc0 == stall_beat && stall_cnt < 10 && job_tvalid) begin
            job_tready = 1'b0;
            stall_cnt++;
         end
         step();
      end
      stop = 1'b0;
      job_tready = 1'b1;
      chk({tag, ":done_seen"}, 128'(n_done), 128'(1));
      repeat (3) step();
      chk({tag, ":done_once"}, 128'(n_done), 128'(1));
      chk({tag, ":done_cycle"}, 128'(done_cyc),
          128'((stop_cyc >= 0 && stop_dly < 6) ? stop_cyc + 2 : last_acc + 2));
      chk({tag, ":all_beats"}, 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      if (num > 0) model_sent = nexp;
      chk({tag, ":jobs_sent"}, 128'(jobs_sent), 128'(model_sent));
      chk({tag, ":busy_seen"}, 128'(busy_seen), 128'(num > 0));
      chk({tag, ":busy_idle"}, 128'(busy), 128'(0));
   endtask

   initial begin
      int a0, f, n;
      job_tready = 1'b1; host_wr_en = 1'b0; host_addr = '0; host_data = '0;
      start = 1'b0; stop = 1'b0; first_idx = '0; num_jobs = '0;
      #2 reset_ni = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset:tvalid", 128'(job_tvalid), 128'(0));
      chk("reset:busy", 128'(busy), 128'(0));
      chk("reset:done", 128'(done), 128'(0));
      chk("reset:jobs_sent", 128'(jobs_sent), 128'(0));
      reset_ni = 1'b1;
      repeat (3) step();

      for (int r = 0; r < 512; r++)
         write_rec(r, $urandom, $urandom, $urandom, $urandom);
      for (int r = 0; r < 3; r++)
         write_rec(r, $urandom, $urandom, $urandom, 32'(256 * (r + 1)));

      run(0, 3, 3, -1, 1'b0, -1, 0, "basic");
      run(0, 3, 3, 1, 1'b0, -1, 0, "stall");
      run(510, 4, 4, -1, 1'b0, -1, 0, "wrap");
      run(7, 0, 0, -1, 1'b0, -1, 0, "zero");
      run(0, 3, 1, -1, 1'b0, 1, 2, "stop_fetch");
      run(0, 3, 2, 1, 1'b0, 1, 7, "stop_send");
      for (int t = 0; t < 5; t++) begin
         f = $urandom_range(0, 511);
         n = $urandom_range(1, 6);
         run(f, n, n, -1, 1'b1, -1, 0, "rand");
      end

      // async reset while a beat is pending
      exp_q.push_back(exp_job(100));
      first_idx = 9'd100; num_jobs = 10'd3; start = 1'b1;
      exp_rise = cyc + 6; last_acc = cyc; a0 = n_acc;
      step();
      start = 1'b0;
      for (int b = 0; b < 40 && n_acc == a0; b++) step();
      job_tready = 1'b0;
      for (int b = 0; b < 40 && !job_tvalid; b++) step();
      chk("rst:pre_tvalid", 128'(job_tvalid), 128'(1));
      chk("rst:pre_sent", 128'(jobs_sent), 128'(1));
      reset_ni = 1'b0;
      #1;
      chk("rst:tvalid", 128'(job_tvalid), 128'(0));
      chk("rst:busy", 128'(busy), 128'(0));
      chk("rst:jobs_sent", 128'(jobs_sent), 128'(0));
      pv = 1'b0; pacc = 1'b0; exp_q.delete(); model_sent = 0;
      step(); step();
      reset_ni = 1'b1;
      job_tready = 1'b1;
      repeat (3) step();
      run(100, 3, 3, -1, 1'b0, -1, 0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1);
   end

endmodule
